// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller.
// State enum, coin codes and coin-to-credit mapping.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN1     = 2'd1;
    localparam logic [1:0] COIN2     = 2'd2;
    localparam logic [1:0] COIN3     = 2'd3;

    function automatic int coin_value(
        input logic [1:0] code,
        input int         v1,
        input int         v2,
        input int         v3
    );
        int val;
        val = 0;
        unique case (1'b1)
            code == COIN1: val = v1;
            code == COIN2: val = v2;
            code == COIN3: val = v3;
            default:       val = 0;
        endcase
        return val;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit accumulator: credit register, coin adder, price compare
// and change subtractor for the vending controller.
module vend_credit_acc #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4,
    parameter int MAX_COIN = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                add_en,
    input  logic [CREDIT_W-1:0] add_val,
    input  logic                clr,
    output logic [CREDIT_W-1:0] credit,
    output logic                reach,
    output logic [CREDIT_W-1:0] change_amt
);

    localparam int NEED = PRICE - 1 + MAX_COIN;
    localparam int CAP  = (1 << CREDIT_W) - 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    // Worst case is one coin short of the price plus the largest coin.
    if (PRICE < 1 || PRICE > CAP || NEED > CAP) begin : g_width_chk
        $error("vend_credit_acc: CREDIT_W too narrow for PRICE/coins");
    end

    logic [CREDIT_W-1:0] sum;

    assign sum        = credit + add_val;
    assign reach      = sum >= PRICE_C;
    assign change_amt = credit - PRICE_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else if (clr) begin
            credit <= '0;
        end else if (add_en) begin
            credit <= sum;
        end
    end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending FSM with coin and change handshakes.
// Optional refund path is built when VEND_CANCEL_EN is defined.
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int PRICE     = 4,
    parameter int COIN1_VAL = 1,
    parameter int COIN2_VAL = 2,
    parameter int COIN3_VAL = 5,
    parameter int CREDIT_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          coin_code,
    input  logic                coin_vld,
    output logic                coin_rdy,
    input  logic                cancel,
    output logic                vend,
    output logic [CREDIT_W-1:0] change_val,
    output logic                change_vld,
    input  logic                change_rdy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int MAX_COIN = max3(COIN1_VAL, COIN2_VAL, COIN3_VAL);

    state_t              state;
    state_t              state_nxt;
    logic                taking;
    logic                fire;
    logic                cancel_act;
    logic                acc_clr;
    logic                reach;
    logic [CREDIT_W-1:0] add_val;
    logic [CREDIT_W-1:0] change_amt;
    logic                vend_d;
    logic                change_vld_d;
    logic [CREDIT_W-1:0] change_val_d;

    assign taking  = (state == IDLE) || (state == COLLECT);
    assign add_val = CREDIT_W'(coin_value(coin_code, COIN1_VAL,
                                          COIN2_VAL, COIN3_VAL));

`ifdef VEND_CANCEL_EN
    assign coin_rdy   = taking && !cancel;
    assign cancel_act = taking && cancel && (credit != '0);
`else
    wire unused_cancel = cancel;
    assign coin_rdy   = taking;
    assign cancel_act = 1'b0;
`endif

    assign fire    = coin_vld && coin_rdy;
    assign acc_clr = ((state == VEND) && (change_amt == '0)) ||
                     ((state == CHANGE) && change_rdy);

    vend_credit_acc #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W),
        .MAX_COIN (MAX_COIN)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .add_en     (fire),
        .add_val    (add_val),
        .clr        (acc_clr),
        .credit     (credit),
        .reach      (reach),
        .change_amt (change_amt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vend       <= 1'b0;
            change_vld <= 1'b0;
            change_val <= '0;
        end else begin
            state      <= state_nxt;
            vend       <= vend_d;
            change_vld <= change_vld_d;
            change_val <= change_val_d;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, COLLECT: begin
                if (cancel_act) begin
                    state_nxt = CHANGE;
                end else if (fire) begin
                    if (reach) begin
                        state_nxt = VEND;
                    end else if (credit == '0 && add_val == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            VEND:    state_nxt = (change_amt != '0) ? CHANGE : IDLE;
            CHANGE:  if (change_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // change_val is captured on entry to CHANGE and frozen until handshake.
    always_comb begin
        vend_d       = (state_nxt == VEND);
        change_vld_d = (state_nxt == CHANGE);
        change_val_d = change_val;
        if (state_nxt != CHANGE) begin
            change_val_d = '0;
        end else if (state != CHANGE) begin
            change_val_d = (state == VEND) ? change_amt : credit;
        end
    end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed self-checking bench for vend_fsm_param (default params).
// Cancel expectations follow VEND_CANCEL_EN when it is defined.
module tb_vend_fsm_param;

    logic       clk;
    logic       rst_n;
    logic [1:0] coin_code;
    logic       coin_vld;
    logic       coin_rdy;
    logic       cancel;
    logic       vend;
    logic [3:0] change_val;
    logic       change_vld;
    logic       change_rdy;
    logic [3:0] credit;

    int n_vec;
    int n_bad;

    vend_fsm_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_code  (coin_code),
        .coin_vld   (coin_vld),
        .coin_rdy   (coin_rdy),
        .cancel     (cancel),
        .vend       (vend),
        .change_val (change_val),
        .change_vld (change_vld),
        .change_rdy (change_rdy),
        .credit     (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input int cr, input int v,
                            input int cv, input int cval, input int rdy);
        chk({tag, ".credit"}, 32'(credit), 32'(cr));
        chk({tag, ".vend"}, 32'(vend), 32'(v));
        chk({tag, ".change_vld"}, 32'(change_vld), 32'(cv));
        chk({tag, ".change_val"}, 32'(change_val), 32'(cval));
        chk({tag, ".coin_rdy"}, 32'(coin_rdy), 32'(rdy));
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        coin_code  = 2'd0;
        coin_vld   = 1'b0;
        cancel     = 1'b0;
        change_rdy = 1'b0;
        #3;
        chk_outs("reset", 0, 0, 0, 0, 1);
        #4;
        rst_n = 1'b1;

        // coins 1,1,2 -> exact price, no change
        coin_vld  = 1'b1;
        coin_code = 2'd1;
        tick;
        chk_outs("c1", 1, 0, 0, 0, 1);
        tick;
        chk_outs("c11", 2, 0, 0, 0, 1);
        coin_code = 2'd2;
        tick;
        chk_outs("c112_vend", 4, 1, 0, 0, 0);
        tick;
        chk_outs("c112_idle", 0, 0, 0, 0, 1);
        coin_vld = 1'b0;
        tick;
        chk_outs("c112_quiet", 0, 0, 0, 0, 1);

        // coins 2,3 -> credit 7, change 3 held under back-pressure
        coin_vld  = 1'b1;
        coin_code = 2'd2;
        tick;
        chk_outs("c2", 2, 0, 0, 0, 1);
        coin_code = 2'd3;
        tick;
        chk_outs("c23_vend", 7, 1, 0, 0, 0);
        tick;
        chk_outs("c23_chg", 7, 0, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_outs("c23_hold", 7, 0, 1, 3, 0);
        end
        coin_vld   = 1'b0;
        change_rdy = 1'b1;
        tick;
        chk_outs("c23_done", 0, 0, 0, 0, 1);
        change_rdy = 1'b0;

        // code 0 is accepted and changes nothing
        coin_vld  = 1'b1;
        coin_code = 2'd1;
        tick;
        chk_outs("pre0", 1, 0, 0, 0, 1);
        coin_code = 2'd0;
        tick;
        chk_outs("code0", 1, 0, 0, 0, 1);
        coin_code = 2'd1;
        tick;
        chk_outs("c_to2", 2, 0, 0, 0, 1);

        // cancel together with a coin
        cancel    = 1'b1;
        coin_code = 2'd1;
        #1;
`ifdef VEND_CANCEL_EN
        chk("cancel.coin_rdy", 32'(coin_rdy), 32'd0);
        tick;
        chk_outs("cancel_chg", 2, 0, 1, 2, 0);
        cancel     = 1'b0;
        coin_vld   = 1'b0;
        change_rdy = 1'b1;
        tick;
        chk_outs("cancel_done", 0, 0, 0, 0, 1);
        change_rdy = 1'b0;
`else
        chk("cancel.coin_rdy", 32'(coin_rdy), 32'd1);
        tick;
        chk_outs("nocancel", 3, 0, 0, 0, 1);
        cancel = 1'b0;
        tick;
        chk_outs("nocancel_vend", 4, 1, 0, 0, 0);
        coin_vld = 1'b0;
        tick;
        chk_outs("nocancel_idle", 0, 0, 0, 0, 1);
`endif

        // change_rdy already high when change appears; then reset mid-CHANGE
        coin_vld  = 1'b1;
        coin_code = 2'd2;
        tick;
        coin_code = 2'd3;
        tick;
        chk_outs("r_vend", 7, 1, 0, 0, 0);
        coin_vld = 1'b0;
        tick;
        chk_outs("r_chg", 7, 0, 1, 3, 0);
        rst_n = 1'b0;
        #1;
        chk_outs("r_async", 0, 0, 0, 0, 1);
        #1;
        rst_n = 1'b1;
        coin_vld  = 1'b1;
        coin_code = 2'd1;
        tick;
        chk_outs("r_after", 1, 0, 0, 0, 1);
        coin_vld = 1'b0;

        // early change_rdy: handshake completes one cycle after change_vld
        coin_vld  = 1'b1;
        coin_code = 2'd3;
        tick;
        chk_outs("e_vend", 6, 1, 0, 0, 0);
        coin_vld   = 1'b0;
        change_rdy = 1'b1;
        tick;
        chk_outs("e_chg", 6, 0, 1, 2, 0);
        tick;
        chk_outs("e_done", 0, 0, 0, 0, 1);
        change_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending-machine controller, successor to the fixed 4-state two-process vending FSM. Accepts coins through a valid/ready handshake and accumulates credit in a counter, with price and coin values set by parameters. Issues a one-cycle vend pulse once credit reaches the price. Returns change, or a refund when the feature is compiled in, through a held valid/ready handshake. Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface
- PRICE, 4, item price in credit units; legal range 1 .. 2^CREDIT_W-1
- COIN1_VAL, 1, credit value of coin code 1
- COIN2_VAL, 2, credit value of coin code 2
- COIN3_VAL, 5, credit value of coin code 3
- CREDIT_W, 4, credit/change width; must hold PRICE-1+max(COINn_VAL)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- coin_code  in  2  0 = none/illegal, 1..3 = coin type
- coin_vld  in  1  coin offered
- coin_rdy  out  1  coin accepted when coin_vld && coin_rdy at rising edge
- cancel  in  1  refund request, level-sampled (VEND_CANCEL_EN only)
- vend  out  1  one-cycle dispense pulse
- change_val  out  CREDIT_W  change amount
- change_vld  out  1  change_val valid; held until accepted
- change_rdy  in  1  hopper accepts change when change_vld && change_rdy
- credit  out  CREDIT_W  current accumulated credit, registered

## Operation
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND, CHANGE.
- coin_rdy = 1 in IDLE/COLLECT only. It is forced to 0 when cancel=1 and VEND_CANCEL_EN is defined. coin_rdy is combinational from state and cancel.
- Accepted coin with code 1..3: credit <= credit + COINn_VAL. Code 0 is accepted, adds 0, and the state is unchanged.
- After an add, if the new credit >= PRICE: go to VEND, which lasts exactly one cycle.
- VEND: vend=1 for that one cycle. Load change_val = credit - PRICE.
  - If change_val > 0, go to CHANGE.
  - Otherwise go to IDLE with credit cleared.
- CHANGE: change_vld=1, and change_val stays stable until the handshake completes. On handshake, clear credit, change_val and change_vld, and go to IDLE.
- Cancel (IDLE/COLLECT, credit > 0): go to CHANGE with change_val = credit; no vend. Cancel with credit 0 has no effect. Cancel in VEND/CHANGE is ignored.
- Cancel and coin_vld in the same cycle: cancel wins, and the coin is not accepted.
- Arithmetic is unsigned, CREDIT_W wide. Parameter legality guarantees no overflow. An elaboration-time check fails if CREDIT_W is too narrow.

## Timing
- Reset (asynchronous, immediate, including mid-CHANGE): state IDLE.
  - credit=0, vend=0, change_val=0, change_vld=0.
  - coin_rdy=1 (with cancel low).
  - A pending change is discarded.
- credit is visible 1 cycle after the accepting edge.
- vend asserts in the cycle after the coin edge that reaches PRICE.
- change_vld asserts the cycle after vend, or the cycle after the sampled cancel.
- change_vld drops the cycle after the change handshake. coin_rdy returns in the same cycle.
- change_rdy may be high before change_vld. Completion requires both to be high at a rising edge.
- All outputs except coin_rdy are registered.

## Configuration
- VEND_CANCEL_EN defined: the cancel/refund path is built as above.
- VEND_CANCEL_EN undefined: the cancel port exists but is ignored. coin_rdy does not depend on cancel, and CHANGE is entered only from VEND.

## Structure
- Package vend_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, CHANGE)
  - coin code constants COIN_NONE/COIN1/COIN2/COIN3
  - a coin-to-value function taking the parameters
- One sub-module, vend_credit_acc. It contains the credit register, the adder, the >= PRICE compare and the change subtractor. The top level holds the state machine and the handshakes.

## Test plan
- Defaults; coins 1,1,2 with coin_vld held -> credit 1,2,4; vend for one cycle; change_vld never asserts; credit returns to 0.
- Coins 2 then 3 -> credit 7; vend; change_val=3, change_vld held with change_rdy low for 3 cycles and stable; change_rdy=1 -> IDLE the next cycle.
- coin_vld=1 during VEND and CHANGE -> coin_rdy=0; credit unchanged; no extra vend.
- VEND_CANCEL_EN: coin 2, then cancel together with coin_vld code 1 -> coin not accepted; change_val=2; vend stays 0. Without the macro: the same stimulus accepts the coin and credit becomes 3.
- coin_vld with code 0 -> accepted; credit and state unchanged.
- rst_n low mid-CHANGE (change_val=3) -> all outputs at reset values immediately; the next coin 1 gives credit 1.
